// File: rtl/rf_wb_sched_if.sv
// Write-back request bus from the N_SRC sources plus the register file write port.
// The scheduler sits on the slave side. Sources and the register file sit on the master side.
interface rf_wb_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_SRC      = 3
);
  logic [N_SRC-1:0]            wb_valid_i;
  logic [N_SRC*5-1:0]          wb_rd_i;
  logic [N_SRC*DATA_WIDTH-1:0] wb_data_i;
  logic [N_SRC-1:0]            wb_ready_o;
  logic                        rf_wen_o;
  logic [4:0]                  rf_rd_o;
  logic [DATA_WIDTH-1:0]       rf_wdata_o;
  logic [DATA_WIDTH/8-1:0]     rf_wstrb_o;

  modport master (
    output wb_valid_i, wb_rd_i, wb_data_i,
    input  wb_ready_o, rf_wen_o, rf_rd_o, rf_wdata_o, rf_wstrb_o
  );

  modport slave (
    input  wb_valid_i, wb_rd_i, wb_data_i,
    output wb_ready_o, rf_wen_o, rf_rd_o, rf_wdata_o, rf_wstrb_o
  );
endinterface

// File: rtl/rf_wb_sched.sv
// Round-robin write-back arbiter feeding a one-stage register file write port,
// with a per-register pending scoreboard that stalls issue on RAW/WAW hazards.
module rf_wb_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int N_SRC      = 3,
  parameter int N_REGS     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid_i,
  input  logic [4:0]        issue_rs1_i,
  input  logic [4:0]        issue_rs2_i,
  input  logic [4:0]        issue_rd_i,
  output logic              issue_stall_o,
  rf_wb_sched_if.slave      wb,
  output logic [N_REGS-1:0] pending_o,
  output logic              err_o
);
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      idx;
  logic                  win_vld;
  logic [4:0]            win_rd;
  logic [DATA_WIDTH-1:0] win_data;

  logic                  rf_wen_q, rf_wen_d;
  logic [4:0]            rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [N_REGS-1:0]     pending_q, pending_d;
  logic                  err_q, err_d;
  logic                  issue_fire;

  // Search upward from the source after the last winner, so priority rotates.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    idx     = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % N_SRC);
      if (!win_vld && wb.wb_valid_i[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    wb.wb_ready_o = '0;
    if (win_vld) wb.wb_ready_o[win_idx] = 1'b1;
  end

  assign win_rd   = wb.wb_rd_i[int'(win_idx)*5 +: 5];
  assign win_data = wb.wb_data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

  assign issue_stall_o = issue_valid_i &
                         (((issue_rs1_i != 5'd0) & pending_q[issue_rs1_i]) |
                          ((issue_rs2_i != 5'd0) & pending_q[issue_rs2_i]) |
                          ((issue_rd_i  != 5'd0) & pending_q[issue_rd_i]));
  assign issue_fire = issue_valid_i & ~issue_stall_o;

  // A granted request with rd=0 still moves the pointer and the address/data, but it does not write.
  always_comb begin
    ptr_d      = win_vld ? win_idx : ptr_q;
    rf_wen_d   = win_vld & (win_rd != 5'd0);
    rf_rd_d    = win_vld ? win_rd : rf_rd_q;
    rf_wdata_d = win_vld ? win_data : rf_wdata_q;
  end

  // A retiring write clears its register on the same edge as the commit. The stall on rd keeps a set of that register from landing on this edge.
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q) pending_d[rf_rd_q] = 1'b0;
    if (issue_fire && (issue_rd_i != 5'd0)) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
    err_d = err_q | (rf_wen_q & ~pending_q[rf_rd_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PTR_W'(N_SRC - 1);
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
    end
  end

  assign wb.rf_wen_o   = rf_wen_q;
  assign wb.rf_rd_o    = rf_rd_q;
  assign wb.rf_wdata_o = rf_wdata_q;
  assign wb.rf_wstrb_o = '1;
  assign pending_o     = pending_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: a cycle-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_rf_wb_sched;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [4:0]    issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic          issue_stall;
  logic [NR-1:0] pending;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  rf_wb_sched_if #(.DATA_WIDTH(DW), .N_SRC(NS)) bus ();

  rf_wb_sched #(.DATA_WIDTH(DW), .N_SRC(NS), .N_REGS(NR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_rs1_i   (issue_rs1),
    .issue_rs2_i   (issue_rs2),
    .issue_rd_i    (issue_rd),
    .issue_stall_o (issue_stall),
    .wb            (bus),
    .pending_o     (pending),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state as the spec describes it. It reads only the inputs and its own state.
  int            m_ptr;
  logic          m_wen, m_err;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_wdata;
  logic [NR-1:0] m_pend;
  int            n_ptr;
  logic          n_wen, n_err;
  logic [4:0]    n_rd;
  logic [DW-1:0] n_wdata;
  logic [NR-1:0] n_pend;
  logic          nxt_ok = 1'b0;
  int            e_win;
  logic [NS-1:0] e_rdy;
  logic          e_stall;
  logic [4:0]    g_rd;

  function automatic int winner(input int ptr, input logic [NS-1:0] v);
    for (int i = 1; i <= NS; i++) begin
      if (v[(ptr + i) % NS]) return (ptr + i) % NS;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] dat(input int k, input logic [4:0] rd);
    return 32'hA000_0000 | (DW'(k) << 8) | DW'(rd);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = NS - 1; m_wen = 1'b0; m_rd = '0; m_wdata = '0; m_pend = '0; m_err = 1'b0;
      nxt_ok = 1'b0;
    end
    e_win   = winner(m_ptr, bus.wb_valid_i);
    e_rdy   = (e_win >= 0) ? NS'(1 << e_win) : '0;
    e_stall = issue_valid && ((issue_rs1 != 0 && m_pend[issue_rs1]) ||
                              (issue_rs2 != 0 && m_pend[issue_rs2]) ||
                              (issue_rd  != 0 && m_pend[issue_rd]));
    chk("ready",   bus.wb_ready_o, e_rdy);
    chk("stall",   issue_stall,    e_stall);
    chk("rf_wen",  bus.rf_wen_o,   m_wen);
    chk("rf_rd",   bus.rf_rd_o,    m_rd);
    chk("rf_data", bus.rf_wdata_o, m_wdata);
    chk("wstrb",   bus.rf_wstrb_o, 4'hF);
    chk("pending", pending,        m_pend);
    chk("err",     err,            m_err);
    if (rst_n) begin
      n_ptr = m_ptr; n_wen = 1'b0; n_rd = m_rd; n_wdata = m_wdata;
      n_pend = m_pend; n_err = m_err;
      if (e_win >= 0) begin
        g_rd    = bus.wb_rd_i[e_win*5 +: 5];
        n_ptr   = e_win;
        n_wen   = (g_rd != 0);
        n_rd    = g_rd;
        n_wdata = bus.wb_data_i[e_win*DW +: DW];
      end
      if (m_wen) begin
        if (!m_pend[m_rd]) n_err = 1'b1;
        n_pend[m_rd] = 1'b0;
      end
      if (issue_valid && !e_stall && issue_rd != 0) n_pend[issue_rd] = 1'b1;
      nxt_ok = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && nxt_ok) begin
      m_ptr = n_ptr; m_wen = n_wen; m_rd = n_rd; m_wdata = n_wdata;
      m_pend = n_pend; m_err = n_err;
      nxt_ok = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
  endtask

  task automatic wb_set(input logic [NS-1:0] v, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    bus.wb_valid_i = v;
    bus.wb_rd_i    = {r2, r1, r0};
    bus.wb_data_i  = {dat(2, r2), dat(1, r1), dat(0, r0)};
  endtask

  logic [14:0]   rd_tab  [6];
  logic [NS-1:0] gnt_tab [6];
  int            iss_tab [6];
  int            lo_tab  [4];

  initial begin
    rd_tab  = '{{5'd3, 5'd2, 5'd1}, {5'd3, 5'd2, 5'd4}, {5'd3, 5'd6, 5'd4},
                {5'd8, 5'd6, 5'd4}, {5'd8, 5'd6, 5'd4}, {5'd8, 5'd6, 5'd4}};
    gnt_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    iss_tab = '{1, 2, 3, 4, 6, 8};
    lo_tab  = '{8, 9, 10, 11};
    wb_set('0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("lit_rst_wen", bus.rf_wen_o, 1'b0);
    chk("lit_rst_pend", pending, '0);
    chk("lit_rst_rd", bus.rf_rd_o, 5'd0);
    rst_n = 1'b1;
    step();

    // Single write-back to x5
    issue(1, 0, 0, 5); #1 chk("lit_t1_stall", issue_stall, 1'b0);
    step(); issue(0, 0, 0, 0);
    chk("lit_t1_pend5", pending[5], 1'b1);
    wb_set(3'b001, 5, 0, 0); bus.wb_data_i[31:0] = 32'hDEADBEEF;
    #1 chk("lit_t1_ready", bus.wb_ready_o, 3'b001);
    step(); wb_set('0, 0, 0, 0);
    chk("lit_t1_wen", bus.rf_wen_o, 1'b1);
    chk("lit_t1_rd", bus.rf_rd_o, 5'd5);
    chk("lit_t1_data", bus.rf_wdata_o, 32'hDEADBEEF);
    chk("lit_t1_strb", bus.rf_wstrb_o, 4'hF);
    step();
    chk("lit_t1_clr", pending[5], 1'b0);
    chk("lit_t1_err", err, 1'b0);

    // A write to x0 from source 2 moves the pointer to 2
    wb_set(3'b100, 0, 0, 0); #1 chk("lit_x0_ready", bus.wb_ready_o, 3'b100);
    step(); wb_set('0, 0, 0, 0);
    chk("lit_x0_wen", bus.rf_wen_o, 1'b0);

    // Round-robin with every source requesting
    for (int i = 0; i < 6; i++) begin
      issue(1, 0, 0, 5'(iss_tab[i])); step();
    end
    issue(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      wb_set(3'b111, rd_tab[i][4:0], rd_tab[i][9:5], rd_tab[i][14:10]);
      #1 chk("lit_rr_grant", bus.wb_ready_o, gnt_tab[i]);
      step();
      chk("lit_rr_wen", bus.rf_wen_o, 1'b1);
    end
    wb_set('0, 0, 0, 0);
    step();
    chk("lit_rr_pend", pending, '0);

    // RAW hazard on x7
    issue(1, 0, 0, 7); step();
    issue(1, 7, 0, 0); #1 chk("lit_raw_stall0", issue_stall, 1'b1);
    step(); chk("lit_raw_stall1", issue_stall, 1'b1);
    wb_set(3'b010, 0, 7, 0); #1 chk("lit_raw_ready", bus.wb_ready_o, 3'b010);
    step(); wb_set('0, 0, 0, 0);
    chk("lit_raw_wen", bus.rf_wen_o, 1'b1);
    chk("lit_raw_stall2", issue_stall, 1'b1);
    step(); chk("lit_raw_free", issue_stall, 1'b0);
    issue(1, 0, 0, 0); #1 chk("lit_raw_x0", issue_stall, 1'b0);
    step(); issue(0, 0, 0, 0);

    // WAW on x9, then a write-back to x0
    issue(1, 0, 0, 9); #1 chk("lit_waw_first", issue_stall, 1'b0);
    step(); chk("lit_waw_second", issue_stall, 1'b1);
    issue(0, 0, 0, 0);
    wb_set(3'b100, 0, 0, 9); #1 chk("lit_waw_ready", bus.wb_ready_o, 3'b100);
    step();
    wb_set(3'b001, 0, 0, 0); #1 chk("lit_wbx0_ready", bus.wb_ready_o, 3'b001);
    step(); wb_set('0, 0, 0, 0);
    chk("lit_wbx0_wen", bus.rf_wen_o, 1'b0);
    step();
    chk("lit_wbx0_err", err, 1'b0);
    chk("lit_wbx0_pend", pending, '0);

    // Write-back to x12, which was never issued
    wb_set(3'b001, 12, 0, 0); #1 chk("lit_err_ready", bus.wb_ready_o, 3'b001);
    step(); wb_set('0, 0, 0, 0);
    chk("lit_err_wen", bus.rf_wen_o, 1'b1);
    chk("lit_err_rd", bus.rf_rd_o, 5'd12);
    chk("lit_err_pre", err, 1'b0);
    step(); chk("lit_err_set", err, 1'b1);
    step(); step(); chk("lit_err_sticky", err, 1'b1);

    // Reset while a write is in flight
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, 0, 5'(lo_tab[i])); step();
    end
    issue(0, 0, 0, 0);
    wb_set(3'b010, 0, 8, 0); #1 chk("lit_mid_ready", bus.wb_ready_o, 3'b010);
    step(); wb_set('0, 0, 0, 0);
    chk("lit_mid_wen", bus.rf_wen_o, 1'b1);
    chk("lit_mid_pend", pending, 32'h0000_0F00);
    rst_n = 1'b0;
    #1;
    chk("lit_arst_wen", bus.rf_wen_o, 1'b0);
    chk("lit_arst_pend", pending, '0);
    chk("lit_arst_err", err, 1'b0);
    step(); rst_n = 1'b1;
    wb_set(3'b111, 0, 0, 0); #1 chk("lit_post_grant", bus.wb_ready_o, 3'b001);
    step(); wb_set('0, 0, 0, 0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end (compared %0d, mismatched %0d)", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
